// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode and ALU control encodings for mc_ctrl_unit
package mc_ctrl_pkg;

  localparam logic [2:0] ST_FETCH      = 3'd0;
  localparam logic [2:0] ST_DECODE     = 3'd1;
  localparam logic [2:0] ST_EXECUTE    = 3'd2;
  localparam logic [2:0] ST_MEMORY     = 3'd3;
  localparam logic [2:0] ST_WRITE_BACK = 3'd4;
  localparam logic [2:0] ST_TRAP       = 3'd5;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] op);
    case (op)
      OP_RTYPE:  return CLS_R;
      OP_ITYPE:  return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      default:   return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - funct3/funct7 to ALUCtrl decode for R-type and I-type ops
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alt,
  input  logic       rtype,
  output logic [3:0] alu_ctrl
);

  // alt is instr[30]: selects SUB only for R-type, SRA for both R and I shifts
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (funct3)
      3'b000:         alu_ctrl = (rtype && alt) ? ALU_SUB : ALU_ADD;
      3'b001:         alu_ctrl = ALU_SLL;
      3'b010, 3'b011: alu_ctrl = ALU_SLT;
      3'b100:         alu_ctrl = ALU_XOR;
      3'b101:         alu_ctrl = alt ? ALU_SRA : ALU_SRL;
      3'b110:         alu_ctrl = ALU_OR;
      3'b111:         alu_ctrl = ALU_AND;
      default:        alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// rtl/mc_ctrl_unit.sv - multicycle control FSM; CTRL_JUMP_EN enables JAL/JALR
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             Ltu,
  input  logic             dReady,
  output logic             PCSrc,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             loadPC,
  output logic [3:0]       ALUCtrl,
  output logic             illegal,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  logic [2:0]   state, state_nx;
  logic         br_taken, br_nx;
  logic [7:0]   wait_cnt;
  logic         legal, take, jump_en;
  logic [3:0]   alu_fn;
  instr_class_e cls;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic         unused_instr_bits;

  assign cls               = classify(instr[6:0]);
  assign funct3            = instr[14:12];
  assign funct7            = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
  assign state_o           = state;

`ifdef CTRL_JUMP_EN
  assign jump_en = 1'b1;
`else
  assign jump_en = 1'b0;
`endif

  mc_alu_decode u_alu_decode (
    .funct3   (funct3),
    .alt      (instr[30]),
    .rtype    (cls == CLS_R),
    .alu_ctrl (alu_fn)
  );

  always_comb begin
    legal = 1'b0;
    case (cls)
      CLS_R:                      legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      CLS_I, CLS_LOAD, CLS_STORE: legal = 1'b1;
      CLS_BRANCH:                 legal = (funct3[2:1] != 2'b01);
      CLS_JAL, CLS_JALR:          legal = jump_en;
      default:                    legal = 1'b0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:  take = Zero;
      3'b001:  take = !Zero;
      3'b100:  take = Lt;
      3'b101:  take = !Lt;
      3'b110:  take = Ltu;
      3'b111:  take = !Ltu;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    br_nx    = br_taken;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    loadPC   = 1'b0;
    ALUCtrl  = ALU_AND;
    case (state)
      ST_FETCH: begin
        loadPC   = 1'b1;
        PCSrc    = br_taken;
        br_nx    = 1'b0;
        state_nx = ST_DECODE;
      end
      ST_DECODE: state_nx = legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        state_nx = ST_WRITE_BACK;
        case (cls)
          CLS_BRANCH: begin
            ALUCtrl  = ALU_SUB;
            br_nx    = take;
            state_nx = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: begin
            ALUCtrl  = ALU_ADD;
            ALUSrc   = 1'b1;
            state_nx = ST_MEMORY;
          end
          CLS_JAL, CLS_JALR: begin
            ALUCtrl = ALU_ADD;
            ALUSrc  = (cls == CLS_JALR);
            br_nx   = 1'b1;
          end
          default: begin
            ALUCtrl = alu_fn;
            ALUSrc  = (cls == CLS_I);
          end
        endcase
      end
      ST_MEMORY: begin
        ALUSrc   = 1'b1;
        MemRead  = (cls == CLS_LOAD);
        MemWrite = (cls == CLS_STORE);
        // dReady wins over the timeout on the last counted cycle
        if (dReady)
          state_nx = (cls == CLS_LOAD) ? ST_WRITE_BACK : ST_FETCH;
        else if (wait_cnt == 8'(MEM_TIMEOUT - 1))
          state_nx = ST_TRAP;
      end
      ST_WRITE_BACK: begin
        RegWrite = 1'b1;
        MemToReg = (cls == CLS_LOAD);
        state_nx = ST_FETCH;
      end
      ST_TRAP: state_nx = ST_TRAP;
      default: state_nx = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_DECODE;
      br_taken  <= 1'b0;
      wait_cnt  <= 8'd0;
      illegal   <= 1'b0;
      mem_fault <= 1'b0;
      instret   <= '0;
    end else begin
      state    <= state_nx;
      br_taken <= br_nx;
      wait_cnt <= (state == ST_MEMORY && state_nx == ST_MEMORY) ? wait_cnt + 8'd1 : 8'd0;
      if (state == ST_DECODE && !legal)
        illegal <= 1'b1;
      if (state == ST_MEMORY && state_nx == ST_TRAP)
        mem_fault <= 1'b1;
      if (state != ST_FETCH && state_nx == ST_FETCH)
        instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: doc/mc_ctrl_unit.md
MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max dReady wait cycles in MEMORY before fault (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port instr  input  32  current instruction, stable from DECODE until the next FETCH.
REQ-006 SHALL have port Zero  input  1  ALU result zero.
REQ-007 SHALL have ports Lt / Ltu  input  1 each  ALU signed / unsigned A<B.
REQ-008 SHALL have port dReady  input  1  data memory access complete this cycle.
REQ-009 SHALL have outputs PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, loadPC  output  1 each  datapath controls.
REQ-010 SHALL have output ALUCtrl  output  4  AND 0000, OR 0001, ADD 0010, SLT 0100, XOR 0101, SUB 0110, SRL 1000, SLL 1001, SRA 1010.
REQ-011 SHALL have outputs illegal, mem_fault  output  1 each  sticky trap causes.
REQ-012 SHALL have output instret  output  CNT_W  retired-instruction count.
REQ-013 SHALL have output state_o  output  3  current state, debug.

Function
REQ-014 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITE_BACK, TRAP; all controls default 0 unless stated.
REQ-015 SHALL go FETCH->DECODE unconditionally, asserting loadPC for exactly that one cycle.
REQ-016 SHALL, in DECODE, go to TRAP with illegal=1 on an unsupported opcode, R-type funct7 other than 0000000/0100000, or branch funct3 010/011; otherwise go to EXECUTE.
REQ-017 SHALL, in EXECUTE, decode ALUCtrl from funct3/funct7[5] (R-type: funct7[5]=1 selects SUB for 000, SRA for 101); ALUSrc=1 for I-type, load, store; I-type 101 selects SRA when instr[30]=1, else SRL.
REQ-018 SHALL, for branches in EXECUTE, drive ALUCtrl=SUB, compute taken for BEQ/BNE/BLT/BGE/BLTU/BGEU from Zero/Lt/Ltu, register it in br_taken, and go to FETCH.
REQ-019 SHALL drive PCSrc=br_taken only in FETCH, then clear br_taken on leaving FETCH.
REQ-020 SHALL go EXECUTE->MEMORY for load/store, EXECUTE->WRITE_BACK for R/I-type.
REQ-021 SHALL, in MEMORY, hold MemRead (load) or MemWrite (store) and ALUSrc=1 every cycle until dReady=1; with dReady=1 the load goes to WRITE_BACK, the store to FETCH.
REQ-022 SHALL count MEMORY wait cycles; when MEM_TIMEOUT cycles elapse with dReady=0, enter TRAP with mem_fault=1. dReady=1 on the final counted cycle completes normally.
REQ-023 SHALL assert RegWrite only in WRITE_BACK, with MemToReg=1 for load, 0 for R/I-type; then go to FETCH.
REQ-024 SHALL increment instret by 1 on every transition into FETCH from a non-reset state, wrapping modulo 2^CNT_W.
REQ-025 SHALL hold TRAP with all controls 0 until rst; illegal/mem_fault stay set.

Reset
REQ-026 SHALL, on rst=1 at a clock edge (any state, including mid-MEMORY wait), set state=DECODE, clear br_taken, wait counter, illegal, mem_fault and instret to 0.
REQ-027 SHALL drive all control outputs to 0 while in the reset state DECODE, and take rst priority over dReady and timeout.

Configuration
REQ-028 SHALL, with CTRL_JUMP_EN defined, support JAL (EXECUTE: br_taken=1, ALUCtrl=ADD; WRITE_BACK: RegWrite=1) and JALR (same, ALUSrc=1, PCSrc=1 in FETCH); without it both opcodes SHALL be illegal per REQ-016.

Structure
REQ-029 SHALL place the state encoding, opcode constants and ALUCtrl codes in shared package mc_ctrl_pkg.
REQ-030 SHALL factor funct-to-ALUCtrl decode into combinational sub-module mc_alu_decode.

Verification
REQ-031 SHALL cover ADD x3,x1,x2 (0x002081B3): DECODE->EXECUTE(ALUCtrl=0010)->WRITE_BACK(RegWrite=1)->FETCH(loadPC=1), instret 0->1.
REQ-032 SHALL cover BNE with Zero=0: PCSrc=1 in following FETCH; with Zero=1: PCSrc=0; no RegWrite in either.
REQ-033 SHALL cover LW with dReady low 3 cycles then high: MemRead high 4 cycles, then WRITE_BACK with MemToReg=1.
REQ-034 SHALL cover SW with dReady never high, MEM_TIMEOUT=4: MemWrite 4 cycles, then TRAP, mem_fault=1, controls 0.
REQ-035 SHALL cover opcode 0x7F: DECODE->TRAP, illegal=1; rst then returns to DECODE with illegal=0, instret=0.
REQ-036 SHALL cover JAL: retires with RegWrite=1 with CTRL_JUMP_EN defined, and TRAP with illegal=1 without it.
